csr_write_sequencer: RTL and testbench

//  Serialises the up-to-NUM_OPS CSR write ops carried by one writeback-stage bundle

---
 rtl/csr_write_sequencer.sv | 145 ++++++++++++++
 tb/tb_csr_write_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/csr_write_sequencer.sv
// Serialises up to NUM_OPS CSR writes from one writeback bundle onto the single CSR write port.
// Optional read bypass of still-pending writes is built when CSR_WSEQ_BYPASS_EN is defined.

module csr_write_slot #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              weBit,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              clear,
    output logic              pend,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            pend <= weBit;
            addr <= addrIn;
            data <= dataIn;
        end else if (clear) begin
            pend <= 1'b0;
        end
    end
endmodule

module csr_write_sequencer #(
    parameter int NUM_OPS = 3,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  logic [NUM_OPS-1:0]        in_we,
    input  logic [NUM_OPS*ADDR_W-1:0] in_addr,
    input  logic [NUM_OPS*DATA_W-1:0] in_data,
    output logic                      in_ready,
    output logic                      stall_o,
    output logic                      csr_we,
    output logic [ADDR_W-1:0]         csr_waddr,
    output logic [DATA_W-1:0]         csr_wdata,
    output logic                      done,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_hit,
    output logic [DATA_W-1:0]         rd_data
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]                     state;
    logic                           accept;
    logic                           inWrite;
    logic [NUM_OPS-1:0]             pendMask;
    logic [NUM_OPS-1:0]             issueOh;
    logic [NUM_OPS-1:0]             remainMask;
    logic [NUM_OPS-1:0][ADDR_W-1:0] slotAddr;
    logic [NUM_OPS-1:0][DATA_W-1:0] slotData;

    assign inWrite = (state == WRITE);
    assign accept  = (state == IDLE) && in_valid && (|in_we);

    for (genvar g = 0; g < NUM_OPS; g++) begin : gSlot
        csr_write_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) uSlot (
            .clk    (clk),
            .resetn (resetn),
            .load   (accept),
            .weBit  (in_we[g]),
            .addrIn (in_addr[g*ADDR_W +: ADDR_W]),
            .dataIn (in_data[g*DATA_W +: DATA_W]),
            .clear  (inWrite && issueOh[g]),
            .pend   (pendMask[g]),
            .addr   (slotAddr[g]),
            .data   (slotData[g])
        );
    end

    // Lowest pending slot issues first; disabled slots never enter the mask, so they cost no cycle.
    always_comb begin
        logic found;
        issueOh = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (pendMask[i] && !found) begin
                issueOh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign remainMask = pendMask & ~issueOh;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else if (accept) begin
            state <= WRITE;
        end else if (inWrite && (remainMask == '0)) begin
            state <= IDLE;
        end
    end

    // Port outputs decode only registered state, so they are zero whenever no write is issued.
    always_comb begin
        csr_waddr = '0;
        csr_wdata = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (inWrite && issueOh[i]) begin
                csr_waddr = slotAddr[i];
                csr_wdata = slotData[i];
            end
        end
    end

    assign csr_we   = inWrite && (|issueOh);
    assign done     = inWrite && (|issueOh) && (remainMask == '0);
    assign stall_o  = accept || (inWrite && (|remainMask));
    assign in_ready = (state == IDLE);

`ifdef CSR_WSEQ_BYPASS_EN
    // Ascending scan: the highest matching pending slot is the value that will land last.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (inWrite && pendMask[i] && (slotAddr[i] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = slotData[i];
            end
        end
    end
`else
    logic unusedRdAddr;
    assign unusedRdAddr = ^rd_addr;
    assign rd_hit       = 1'b0;
    assign rd_data      = '0;
`endif
endmodule

// File: tb/tb_csr_write_sequencer.sv
// Directed bench for csr_write_sequencer: vector table for bundles plus reset and bypass sequences.

module tb_csr_write_sequencer;
    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic [2:0]   in_we;
    logic [35:0]  in_addr;
    logic [191:0] in_data;
    logic         in_ready, stall_o, csr_we, done, rd_hit;
    logic [11:0]  csr_waddr, rd_addr;
    logic [63:0]  csr_wdata, rd_data;

    int errors = 0;
    int checks = 0;
    int writeCnt = 0;
    logic [63:0] csrMem [0:4095];

    csr_write_sequencer #(.NUM_OPS(3), .ADDR_W(12), .DATA_W(64)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_we(in_we),
        .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready), .stall_o(stall_o),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .done(done),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Stand-in CSR file: commits whatever the port presents on each rising edge.
    always @(posedge clk) begin
        if (csr_we) begin
            csrMem[csr_waddr] <= csr_wdata;
            writeCnt <= writeCnt + 1;
        end
    end

    typedef struct packed {
        logic [2:0]        we;
        logic [2:0][11:0]  addr;
        logic [2:0][63:0]  data;
        logic [1:0]        nw;
        logic [2:0][11:0]  expAddr;
        logic [2:0][63:0]  expData;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] we, input logic [2:0][11:0] a, input logic [2:0][63:0] d);
        in_valid = 1'b1;
        in_we    = we;
        in_addr  = a;
        in_data  = d;
    endtask

    task automatic idleChk(input string nm);
        chk({nm, ".ready"}, {63'd0, in_ready}, 64'd1);
        chk({nm, ".we"},    {63'd0, csr_we},   64'd0);
        chk({nm, ".stall"}, {63'd0, stall_o},  64'd0);
        chk({nm, ".done"},  {63'd0, done},     64'd0);
    endtask

    initial begin
        vecs[0] = '{we: 3'b010, addr: {12'h0, 12'h300, 12'h0}, data: {64'h0, 64'h8, 64'h0},
                    nw: 2'd1, expAddr: {12'h0, 12'h0, 12'h300}, expData: {64'h0, 64'h0, 64'h8}};
        vecs[1] = '{we: 3'b111, addr: {12'h300, 12'h342, 12'h341}, data: {64'h33, 64'h22, 64'h11},
                    nw: 2'd3, expAddr: {12'h300, 12'h342, 12'h341}, expData: {64'h33, 64'h22, 64'h11}};
        vecs[2] = '{we: 3'b101, addr: {12'h305, 12'h3FF, 12'h305}, data: {64'hB, 64'h99, 64'hA},
                    nw: 2'd2, expAddr: {12'h0, 12'h305, 12'h305}, expData: {64'h0, 64'hB, 64'hA}};
        vecs[3] = '{we: 3'b000, addr: {12'h111, 12'h222, 12'h333}, data: {64'h1, 64'h2, 64'h3},
                    nw: 2'd0, expAddr: '0, expData: '0};
        vecs[4] = '{we: 3'b100, addr: {12'hFFF, 12'h0, 12'h0}, data: {64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 64'h6},
                    nw: 2'd1, expAddr: {12'h0, 12'h0, 12'hFFF}, expData: {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF}};
        vecs[5] = '{we: 3'b110, addr: {12'h7C2, 12'h7C1, 12'h7C0}, data: {64'hC2, 64'hC1, 64'hC0},
                    nw: 2'd2, expAddr: {12'h0, 12'h7C2, 12'h7C1}, expData: {64'h0, 64'hC2, 64'hC1}};

        for (int i = 0; i < 4096; i++) csrMem[i] = '0;
        resetn = 1'b0; in_valid = 1'b0; in_we = '0; in_addr = '0; in_data = '0; rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idleChk("reset");
        chk("reset.waddr", {52'd0, csr_waddr}, 64'd0);
        chk("reset.wdata", csr_wdata, 64'd0);
        chk("reset.rdhit", {63'd0, rd_hit}, 64'd0);
        @(posedge clk); #1 resetn = 1'b1;

        // Table-driven bundles.
        for (int v = 0; v < 6; v++) begin
            @(posedge clk); #1;
            drive(vecs[v].we, vecs[v].addr, vecs[v].data);
            @(negedge clk);
            chk($sformatf("v%0d.T.ready", v), {63'd0, in_ready}, 64'd1);
            chk($sformatf("v%0d.T.stall", v), {63'd0, stall_o}, {63'd0, vecs[v].nw != 0});
            chk($sformatf("v%0d.T.we", v), {63'd0, csr_we}, 64'd0);
            for (int k = 0; k < int'(vecs[v].nw); k++) begin
                @(posedge clk); #1;
                if (k == int'(vecs[v].nw) - 1) in_valid = 1'b0;
                @(negedge clk);
                chk($sformatf("v%0d.w%0d.we", v, k), {63'd0, csr_we}, 64'd1);
                chk($sformatf("v%0d.w%0d.waddr", v, k), {52'd0, csr_waddr}, {52'd0, vecs[v].expAddr[k]});
                chk($sformatf("v%0d.w%0d.wdata", v, k), csr_wdata, vecs[v].expData[k]);
                chk($sformatf("v%0d.w%0d.done", v, k), {63'd0, done}, {63'd0, k == int'(vecs[v].nw) - 1});
                chk($sformatf("v%0d.w%0d.stall", v, k), {63'd0, stall_o}, {63'd0, k < int'(vecs[v].nw) - 1});
                chk($sformatf("v%0d.w%0d.ready", v, k), {63'd0, in_ready}, 64'd0);
            end
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            idleChk($sformatf("v%0d.after", v));
        end
        chk("dup.final", csrMem[12'h305], 64'hB);
        chk("skip.slot1", csrMem[12'h3FF], 64'h0);
        chk("nowe.mem", csrMem[12'h222], 64'h0);

        // Reset in the middle of a full bundle: only slot 0 commits.
        @(posedge clk); #1;
        drive(3'b111, {12'h7A2, 12'h7A1, 12'h7A0}, {64'h2, 64'h1, 64'h5A});
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("rst.w0.we", {63'd0, csr_we}, 64'd1);
        chk("rst.w0.waddr", {52'd0, csr_waddr}, 64'h7A0);
        @(posedge clk); #1 resetn = 1'b0;
        #1;
        idleChk("rst.async");
        chk("rst.waddr", {52'd0, csr_waddr}, 64'd0);
        chk("rst.wdata", csr_wdata, 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        idleChk("rst.post");
        chk("rst.slot0", csrMem[12'h7A0], 64'h5A);
        chk("rst.slot1", csrMem[12'h7A1], 64'h0);
        chk("rst.slot2", csrMem[12'h7A2], 64'h0);

        // Bypass of pending writes with a duplicated address.
        @(posedge clk); #1;
        rd_addr = 12'h340;
        drive(3'b011, {12'h0, 12'h340, 12'h340}, {64'h0, 64'h2, 64'h1});
        @(negedge clk);
        chk("byp.T.hit", {63'd0, rd_hit}, 64'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
`ifdef CSR_WSEQ_BYPASS_EN
            chk($sformatf("byp.T%0d.hit", k), {63'd0, rd_hit}, {63'd0, k < 3});
            chk($sformatf("byp.T%0d.data", k), rd_data, (k < 3) ? 64'h2 : 64'h0);
`else
            chk($sformatf("byp.T%0d.hit", k), {63'd0, rd_hit}, 64'd0);
            chk($sformatf("byp.T%0d.data", k), rd_data, 64'h0);
`endif
        end
        chk("byp.final", csrMem[12'h340], 64'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
